// File: rtl/shape_sfr_pkg.sv
// Shared types and field layout for the shape processor SFR initiator.
// SHAPE_SFR_INITIATOR_READBACK_EN adds the two verify-read states to the FSM enum.
package shape_sfr_pkg;

  localparam int SHAPE_LSB = 16;
  localparam int SHAPE_W   = 2;
  localparam int OP_LSB    = 0;
  localparam int OP_W      = 5;

  typedef struct packed {
    logic               is_read;
    logic [SHAPE_W-1:0] shape;
    logic [OP_W-1:0]    operation;
  } sfr_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
    ST_RB_ISSUE = 3'd4,
    ST_RB_WAIT  = 3'd5,
`endif
    ST_RESP     = 3'd3
  } sfr_state_e;

  function automatic logic [31:0] pack_ctrl(input logic [SHAPE_W-1:0] shape,
                                            input logic [OP_W-1:0]    operation);
    logic [31:0] word;
    word = '0;
    word[SHAPE_LSB +: SHAPE_W] = shape;
    word[OP_LSB +: OP_W]       = operation;
    return word;
  endfunction

endpackage

// File: rtl/sfr_cmd_fifo.sv
// Command queue for the SFR initiator: DEPTH entries of sfr_cmd_t, first-word-fall-through head.
module sfr_cmd_fifo
  import shape_sfr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  sfr_cmd_t push_data_i,
  input  logic     pop_i,
  output sfr_cmd_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  sfr_cmd_t    mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/shape_sfr_initiator.sv
// Shape SFR initiator: queues register commands and runs one strobed SFR access at a time.
// Build option SHAPE_SFR_INITIATOR_READBACK_EN verifies every write with a follow-up read.
module shape_sfr_initiator
  import shape_sfr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RSP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_read,
  input  logic [SHAPE_W-1:0] cmd_shape,
  input  logic [OP_W-1:0]   cmd_operation,
  output logic              write,
  output logic [31:0]       write_data,
  output logic              read,
  input  logic [31:0]       read_data,
  input  logic              error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_read,
  output logic [31:0]       rsp_data,
  output logic              rsp_error,
  output logic [7:0]        err_cnt
);

  // state       | meaning
  // IDLE        | waiting for a queued command
  // ISSUE       | one-cycle write or read strobe
  // WAIT        | down-count to the cycle where read_data/error are valid
  // RB_ISSUE    | verify-read strobe after a write (readback build only)
  // RB_WAIT     | down-count for the verify-read (readback build only)
  // RESP        | response held until rsp_ready

  localparam int            CW       = $clog2(RSP_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RSP_LATENCY - 1);

  sfr_state_e    state_q, state_d;
  sfr_cmd_t      push_cmd, head;
  logic          fifo_full, fifo_empty, push, pop;
  logic          is_read_q, is_read_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_is_read_q, rsp_is_read_d;
  logic          rsp_error_q, rsp_error_d;
  logic [7:0]    err_cnt_q;
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
  logic          wr_err_q, wr_err_d;
  logic          rb_mismatch;
`endif

  assign push_cmd  = {cmd_is_read, cmd_shape, cmd_operation};
  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  sfr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    is_read_d     = is_read_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    rsp_data_d    = rsp_data_q;
    rsp_is_read_d = rsp_is_read_q;
    rsp_error_d   = rsp_error_q;
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
    wr_err_d      = wr_err_q;
    rb_mismatch   = (read_data[SHAPE_LSB +: SHAPE_W] != wdata_q[SHAPE_LSB +: SHAPE_W]) ||
                    (read_data[OP_LSB +: OP_W] != wdata_q[OP_LSB +: OP_W]);
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          is_read_d = head.is_read;
          if (!head.is_read) wdata_d = pack_ctrl(head.shape, head.operation);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
          if (!is_read_q) begin
            wr_err_d = error;
            state_d  = ST_RB_ISSUE;
          end else begin
            rsp_is_read_d = 1'b1;
            rsp_data_d    = read_data;
            rsp_error_d   = error;
            state_d       = ST_RESP;
          end
`else
          rsp_is_read_d = is_read_q;
          rsp_data_d    = is_read_q ? read_data : 32'd0;
          rsp_error_d   = error;
          state_d       = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
      ST_RB_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_RB_WAIT;
      end
      ST_RB_WAIT: begin
        if (cnt_q == '0) begin
          rsp_is_read_d = 1'b0;
          rsp_data_d    = read_data;
          rsp_error_d   = wr_err_q | error | rb_mismatch;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      is_read_q     <= 1'b0;
      cnt_q         <= '0;
      wdata_q       <= '0;
      rsp_data_q    <= '0;
      rsp_is_read_q <= 1'b0;
      rsp_error_q   <= 1'b0;
      err_cnt_q     <= '0;
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
      wr_err_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      cnt_q         <= cnt_d;
      wdata_q       <= wdata_d;
      rsp_data_q    <= rsp_data_d;
      rsp_is_read_q <= rsp_is_read_d;
      rsp_error_q   <= rsp_error_d;
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
      wr_err_q      <= wr_err_d;
`endif
      if (state_q == ST_RESP && rsp_ready && rsp_error_q && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Strobes decode straight from the state register so reset removes them immediately.
  assign write = (state_q == ST_ISSUE) && !is_read_q;
`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
  assign read  = ((state_q == ST_ISSUE) && is_read_q) || (state_q == ST_RB_ISSUE);
`else
  assign read  = (state_q == ST_ISSUE) && is_read_q;
`endif
  assign write_data  = wdata_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_is_read = rsp_is_read_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_shape_sfr_initiator.sv
// Directed bench for shape_sfr_initiator (DEPTH=4, RSP_LATENCY=1) with a small SFR slave model.
module tb_shape_sfr_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_read = 1'b0;
  logic [1:0]  cmd_shape = 2'd0;
  logic [4:0]  cmd_operation = 5'd0;
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic [31:0] read_data = 32'd0;
  logic        error = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_is_read;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [7:0]  err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // SFR slave model controls, written only by the stimulus block
  int          err_mode   = 0;   // 0 none, 1 only strobe number err_idx, 2 every strobe
  int          err_idx    = 0;
  logic        fixed_en   = 1'b0;
  logic [31:0] fixed_word = 32'd0;
  int          n_strobe   = 0;   // written only by the model

  shape_sfr_initiator #(.DEPTH(4), .RSP_LATENCY(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_is_read   (cmd_is_read),
    .cmd_shape     (cmd_shape),
    .cmd_operation (cmd_operation),
    .write         (write),
    .write_data    (write_data),
    .read          (read),
    .read_data     (read_data),
    .error         (error),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_is_read   (rsp_is_read),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // Slave answers each strobe; data/error stay put until the next strobe, covering latency 1.
  always @(negedge clk) begin
    if (write || read) begin
      n_strobe  = n_strobe + 1;
      error     = (err_mode == 2) || (err_mode == 1 && n_strobe == err_idx);
      read_data = fixed_en ? fixed_word : (32'hC0DE_0000 | n_strobe);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_rsp(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  // Streams n reads with rsp_ready high; returns how many responses were seen.
  task automatic batch_reads(input int n, output int n_rsp);
    int acc;
    acc         = 0;
    n_rsp       = 0;
    cmd_is_read = 1'b1;
    cmd_valid   = 1'b1;
    for (int i = 0; i < n * 8 + 50; i++) begin
      if (rsp_valid) n_rsp = n_rsp + 1;
      if (cmd_valid && cmd_ready) acc = acc + 1;
      tick();
      if (acc == n) cmd_valid = 1'b0;
      if (n_rsp == n) break;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int s0, acc, n_rsp, exp_err;
    logic seen;
    exp_err = 0;

    // reset state
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;

`ifndef SHAPE_SFR_INITIATOR_READBACK_EN
    // single write shape=2 op=5
    cmd_valid = 1'b1; cmd_is_read = 1'b0; cmd_shape = 2'd2; cmd_operation = 5'd5;
    tick();
    cmd_valid = 1'b0;
    check("wr_no_early_strobe", {31'd0, write}, 32'd0);
    tick();
    check("wr_strobe", {31'd0, write}, 32'd1);
    check("wr_no_read", {31'd0, read}, 32'd0);
    check("wr_data", write_data, 32'h0002_0005);
    tick();
    check("wr_strobe_one_cycle", {31'd0, write}, 32'd0);
    check("wr_data_hold", write_data, 32'h0002_0005);
    check("wr_rsp_not_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_is_read", {31'd0, rsp_is_read}, 32'd0);
    check("wr_rsp_data", rsp_data, 32'd0);
    check("wr_rsp_error", {31'd0, rsp_error}, 32'd0);
    tick();
    check("wr_rsp_done", {31'd0, rsp_valid}, 32'd0);
`endif

    // single read
    fixed_en = 1'b1; fixed_word = 32'h0003_001F;
    cmd_valid = 1'b1; cmd_is_read = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rd_strobe", {31'd0, read}, 32'd1);
    check("rd_no_write", {31'd0, write}, 32'd0);
    tick();
    check("rd_strobe_one_cycle", {31'd0, read}, 32'd0);
    tick();
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_data", rsp_data, 32'h0003_001F);
    check("rd_rsp_is_read", {31'd0, rsp_is_read}, 32'd1);
    check("rd_rsp_error", {31'd0, rsp_error}, 32'd0);
    tick();

`ifdef SHAPE_SFR_INITIATOR_READBACK_EN
    // write with verify-read returning a wrong operation field
    fixed_word = 32'h0001_0004;
    cmd_valid = 1'b1; cmd_is_read = 1'b0; cmd_shape = 2'd1; cmd_operation = 5'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rb_wr_strobe", {31'd0, write}, 32'd1);
    check("rb_wr_data", write_data, 32'h0001_0003);
    tick();
    tick();
    check("rb_read_strobe", {31'd0, read}, 32'd1);
    check("rb_no_write", {31'd0, write}, 32'd0);
    tick();
    tick();
    check("rb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rb_rsp_is_read", {31'd0, rsp_is_read}, 32'd0);
    check("rb_rsp_data", rsp_data, 32'h0001_0004);
    check("rb_rsp_error", {31'd0, rsp_error}, 32'd1);
    tick();
    exp_err = exp_err + 1;
    check("rb_err_cnt", {24'd0, err_cnt}, exp_err);
`endif

    // backpressure: 5 reads, first one goes out, 4 fill the queue
    fixed_en = 1'b0;
    rsp_ready = 1'b0;
    s0 = n_strobe;
    acc = 0;
    cmd_is_read = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      if (cmd_ready) acc = acc + 1;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", acc, 32'd5);
    check("bp_full", {31'd0, cmd_ready}, 32'd0);
    repeat (6) tick();
    check("bp_one_strobe", n_strobe - s0, 32'd1);
    check("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
    check("bp_still_full", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp("bp_rsp_seen");
      check("bp_rsp_order", rsp_data, 32'hC0DE_0000 | (s0 + 1 + k));
      check("bp_rsp_is_read", {31'd0, rsp_is_read}, 32'd1);
      tick();
    end
    check("bp_ready_again", {31'd0, cmd_ready}, 32'd1);

    // error on the 2nd of 3 accesses
    err_mode = 1;
    err_idx = n_strobe + 2;
    acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      if (cmd_ready) acc = acc + 1;
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_rsp("err_rsp_seen");
      check("err_rsp_flag", {31'd0, rsp_error}, (k == 1) ? 32'd1 : 32'd0);
      tick();
    end
    exp_err = exp_err + 1;
    check("err_cnt_one", {24'd0, err_cnt}, exp_err);

    // saturation: bring the count to 254, then push past 255
    err_mode = 2;
    batch_reads(254 - exp_err, n_rsp);
    check("sat_batch_a_rsp", n_rsp, 254 - exp_err);
    check("err_cnt_254", {24'd0, err_cnt}, 32'd254);
    batch_reads(47, n_rsp);
    check("sat_batch_b_rsp", n_rsp, 32'd47);
    check("err_cnt_255", {24'd0, err_cnt}, 32'd255);

    // reset during WAIT with a second command still queued
    err_mode = 0;
    cmd_is_read = 1'b1;
    cmd_valid = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    check("abort_strobe", {31'd0, read}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_read", {31'd0, read}, 32'd0);
    check("abort_write", {31'd0, write}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    s0 = n_strobe;
    seen = 1'b0;
    repeat (10) begin
      if (rsp_valid || read || write) seen = 1'b1;
      tick();
    end
    check("abort_no_activity", {31'd0, seen}, 32'd0);
    check("abort_no_strobe", n_strobe - s0, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
